// File: rtl/aes_enc_iter.sv
// Iterative AES encryptor: one full round per enabled clock, round keys
// expanded on the fly from a single key-width expansion register.
// KEY_BITS selects AES-128 (10 rounds) or AES-256 (14 rounds).
module aes_enc_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        data_in,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        data_out,
    output logic                busy
);

    localparam int         NR         = (KEY_BITS == 128) ? 10 : 14;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_iter: KEY_BITS must be 128 or 256");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // S-box as multiplicative inverse (x^254, which maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] m0, m1, m2, m3;
        a0 = c[7:0];
        a1 = c[15:8];
        a2 = c[23:16];
        a3 = c[31:24];
        m0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        m1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        m2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        m3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {m3, m2, m1, m0};
    endfunction

    // SubBytes, ShiftRows and (except in the last round) MixColumns.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
        logic [127:0] sb;
        logic [127:0] sr;
        logic [127:0] mc;
        for (int b = 0; b < 16; b++) sb[8*b +: 8] = sbox(s[8*b +: 8]);
        for (int b = 0; b < 16; b++) sr[8*b +: 8] = sb[8*((b + 4*(b % 4)) % 16) +: 8];
        for (int c = 0; c < 4; c++) mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
        return last ? sr : mc;
    endfunction

    // Next four schedule words: lo4 holds w[i-Nk..i-Nk+3], last is w[i-1].
    function automatic logic [127:0] expand_key(input logic [127:0] lo4, input logic [31:0] last,
                                                input logic rot, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = rot ? (sub_word({last[7:0], last[31:8]}) ^ {24'h0, rc}) : sub_word(last);
        n0 = lo4[31:0] ^ t;
        n1 = lo4[63:32] ^ n0;
        n2 = lo4[95:64] ^ n1;
        n3 = lo4[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    state_e              fsm_q, fsm_d;
    logic [127:0]        aes_q, aes_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [3:0]          round_q, round_d;
    logic [7:0]          rcon_q, rcon_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [127:0]        data_out_q, data_out_d;
    logic                busy_q, busy_d;

    logic [127:0]        exp_words;
    logic [127:0]        round_key;
    logic [KEY_BITS-1:0] key_next;
    logic                rcon_step;
    logic [127:0]        round_out;

    if (KEY_BITS == 128) begin : g_aes128
        assign exp_words = expand_key(key_q[127:0], key_q[127:96], 1'b1, rcon_q);
        assign round_key = exp_words;
        assign key_next  = exp_words;
        assign rcon_step = 1'b1;
    end else begin : g_aes256
        // Round 1 uses the upper key half as-is; afterwards even rounds take RotWord+Rcon
        // and odd rounds take the extra SubWord-only step.
        logic even_round;
        assign even_round = ~round_q[0];
        assign exp_words  = expand_key(key_q[127:0], key_q[255:224], even_round, rcon_q);
        assign round_key  = (round_q == 4'd1) ? key_q[255:128] : exp_words;
        assign key_next   = (round_q == 4'd1) ? key_q : {exp_words, key_q[255:128]};
        assign rcon_step  = even_round;
    end

    assign round_out = aes_round(aes_q, round_q == LAST_ROUND) ^ round_key;

    // Next-state decode; everything holds unless clk_en is high.
    always_comb begin
        fsm_d       = fsm_q;
        aes_d       = aes_q;
        key_d       = key_q;
        round_d     = round_q;
        rcon_d      = rcon_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        busy_d      = busy_q;
        if (clk_en) begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        aes_d      = data_in ^ key[127:0];
                        key_d      = key;
                        round_d    = 4'd1;
                        rcon_d     = 8'h01;
                        fsm_d      = ROUND;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end
                end
                ROUND: begin
                    aes_d   = round_out;
                    key_d   = key_next;
                    round_d = round_q + 4'd1;
                    rcon_d  = rcon_step ? xtime(rcon_q) : rcon_q;
                    if (round_q == LAST_ROUND) begin
                        fsm_d       = DONE;
                        out_valid_d = 1'b1;
                        data_out_d  = round_out;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_d       = IDLE;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous reset that overrides clk_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            aes_q       <= '0;
            key_q       <= '0;
            round_q     <= '0;
            rcon_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            aes_q       <= aes_d;
            key_q       <= key_d;
            round_q     <= round_d;
            rcon_q      <= rcon_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Testbench for aes_enc_iter: one AES-128 and one AES-256 instance, checked
// against FIPS-197 vectors and a byte-array reference model of the cipher.
module tb_aes_enc_iter;

    localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] P1 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] C1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [255:0] K3 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C3 = 128'h8960494b9049fceabf456751cab7a28e;
    localparam logic [127:0] CZ = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clk_en = 1'b0;
    logic [127:0] data_in = '0;
    logic         out_ready = 1'b0;

    logic         in_valid128 = 1'b0;
    logic [127:0] key128 = '0;
    logic         in_ready128, out_valid128, busy128;
    logic [127:0] data_out128;

    logic         in_valid256 = 1'b0;
    logic [255:0] key256 = '0;
    logic         in_ready256, out_valid256, busy256;
    logic [127:0] data_out256;

    int tests = 0;
    int fails = 0;

    logic [7:0] sbox_t [256];

    aes_enc_iter #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .in_valid(in_valid128), .in_ready(in_ready128),
        .data_in(data_in), .key(key128),
        .out_valid(out_valid128), .out_ready(out_ready),
        .data_out(data_out128), .busy(busy128)
    );

    aes_enc_iter #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .in_valid(in_valid256), .in_ready(in_ready256),
        .data_in(data_in), .key(key256),
        .out_valid(out_valid256), .out_ready(out_ready),
        .data_out(data_out256), .busy(busy256)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Build the S-box by brute-force inversion plus the bitwise affine formula.
    task automatic build_sbox;
        logic [7:0] inv, s, xb;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox_t[x] = s ^ 8'h63;
        end
    endtask

    // Reference cipher with a full expanded key schedule held in an array.
    function automatic logic [127:0] ref_encrypt(input logic [255:0] k, input logic [127:0] pt, input int nk);
        logic [7:0] w [0:59][0:3];
        logic [7:0] st [0:15];
        logic [7:0] tmp [0:15];
        logic [7:0] t [0:3];
        logic [7:0] a [0:3];
        logic [7:0] rc, x;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++)
            for (int j = 0; j < 4; j++) w[i][j] = k[8*(4*i+j) +: 8];
        for (int i = nk; i < 4*(nr+1); i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % nk == 0) begin
                x = t[0];
                t[0] = sbox_t[t[1]] ^ rc;
                t[1] = sbox_t[t[2]];
                t[2] = sbox_t[t[3]];
                t[3] = sbox_t[x];
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) t[j] = sbox_t[t[j]];
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-nk][j] ^ t[j];
        end
        for (int b = 0; b < 16; b++) st[b] = pt[8*b +: 8] ^ w[b/4][b%4];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int b = 0; b < 16; b++) tmp[b] = sbox_t[st[b]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) st[r+4*c] = tmp[r+4*((c+r)%4)];
            if (rnd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = st[r+4*c];
                    for (int r = 0; r < 4; r++)
                        st[r+4*c] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int b = 0; b < 16; b++) st[b] = st[b] ^ w[4*rnd + b/4][b%4];
        end
        for (int b = 0; b < 16; b++) res[8*b +: 8] = st[b];
        return res;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one job with out_ready high and return the ciphertext and latency (-1 on timeout).
    task automatic run_job(input bit m256, input logic [255:0] k, input logic [127:0] pt,
                           output logic [127:0] ct, output int lat);
        lat = -1;
        ct  = '0;
        data_in = pt;
        key128  = k[127:0];
        key256  = k;
        if (m256) in_valid256 = 1'b1; else in_valid128 = 1'b1;
        tick();
        in_valid128 = 1'b0;
        in_valid256 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if ((m256 ? out_valid256 : out_valid128) === 1'b1) begin
                lat = n;
                ct  = m256 ? data_out256 : data_out128;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset;
        clk_en = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (in_ready128 !== 1'b1 || out_valid128 !== 1'b0 || busy128 !== 1'b0 || data_out128 !== 128'h0) begin
            fails++;
            $display("[TB] FAIL reset128: in_ready=%b out_valid=%b busy=%b data_out=%h, want 1 0 0 0",
                     in_ready128, out_valid128, busy128, data_out128);
        end
        tests++;
        if (in_ready256 !== 1'b1 || out_valid256 !== 1'b0 || busy256 !== 1'b0 || data_out256 !== 128'h0) begin
            fails++;
            $display("[TB] FAIL reset256: in_ready=%b out_valid=%b busy=%b data_out=%h, want 1 0 0 0",
                     in_ready256, out_valid256, busy256, data_out256);
        end
        clk_en = 1'b1;
        out_ready = 1'b1;
        data_in = P1;
        key128 = K1;
        rst = 1'b1;
        in_valid128 = 1'b1;
        tick();
        rst = 1'b0;
        in_valid128 = 1'b0;
        tick();
        tests++;
        if (busy128 !== 1'b0 || in_ready128 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_with_valid: busy=%b in_ready=%b, want 0 1", busy128, in_ready128);
        end
    endtask

    task automatic test_fips128;
        logic [127:0] ct;
        int lat;
        run_job(1'b0, {128'h0, K1}, P1, ct, lat);
        tests++;
        if (lat != 10) begin
            fails++;
            $display("[TB] FAIL fips128_latency: got %0d want 10", lat);
        end
        tests++;
        if (ct !== C1) begin
            fails++;
            $display("[TB] FAIL fips128_data: got %h want %h", ct, C1);
        end
        tests++;
        if (out_valid128 !== 1'b0 || in_ready128 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL fips128_one_cycle: out_valid=%b in_ready=%b, want 0 1", out_valid128, in_ready128);
        end
    endtask

    task automatic test_fips256;
        logic [127:0] ct;
        int lat;
        run_job(1'b1, K3, P1, ct, lat);
        tests++;
        if (lat != 14) begin
            fails++;
            $display("[TB] FAIL fips256_latency: got %0d want 14", lat);
        end
        tests++;
        if (ct !== C3) begin
            fails++;
            $display("[TB] FAIL fips256_data: got %h want %h", ct, C3);
        end
        tests++;
        if (out_valid256 !== 1'b0 || in_ready256 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL fips256_one_cycle: out_valid=%b in_ready=%b, want 0 1", out_valid256, in_ready256);
        end
    endtask

    task automatic test_random;
        logic [255:0] k;
        logic [127:0] pt, ct, exp_ct;
        int lat;
        for (int j = 0; j < 8; j++) begin
            bit m256;
            m256 = (j % 2 == 1);
            for (int w = 0; w < 8; w++) k[32*w +: 32] = $urandom;
            for (int w = 0; w < 4; w++) pt[32*w +: 32] = $urandom;
            if (j == 2) pt = '1;
            exp_ct = ref_encrypt(k, pt, m256 ? 8 : 4);
            run_job(m256, k, pt, ct, lat);
            tests++;
            if (ct !== exp_ct || lat != (m256 ? 14 : 10)) begin
                fails++;
                $display("[TB] FAIL random_%0d_aes%0d: got %h lat %0d want %h lat %0d",
                         j, m256 ? 256 : 128, ct, lat, exp_ct, m256 ? 14 : 10);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        data_in = P1;
        key128 = K1;
        in_valid128 = 1'b1;
        tick();
        in_valid128 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (out_valid128 === 1'b1) begin
                lat = n;
                break;
            end
        end
        tests++;
        if (lat != 10 || data_out128 !== C1) begin
            fails++;
            $display("[TB] FAIL bp_first: lat %0d data %h want 10 %h", lat, data_out128, C1);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid128 = 1'b1;
            data_in = {$urandom, $urandom, $urandom, $urandom};
            key128 = {$urandom, $urandom, $urandom, $urandom};
            tick();
            tests++;
            if (out_valid128 !== 1'b1 || data_out128 !== C1 || in_ready128 !== 1'b0) begin
                fails++;
                $display("[TB] FAIL bp_hold_%0d: out_valid=%b data=%h in_ready=%b want 1 %h 0",
                         i, out_valid128, data_out128, in_ready128, C1);
            end
        end
        in_valid128 = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid128 !== 1'b0 || in_ready128 !== 1'b1 || data_out128 !== C1) begin
            fails++;
            $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b data=%h want 0 1 %h",
                     out_valid128, in_ready128, data_out128, C1);
        end
        tick();
        tick();
        tests++;
        if (busy128 !== 1'b0 || out_valid128 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_not_queued: busy=%b out_valid=%b want 0 0", busy128, out_valid128);
        end
    endtask

    task automatic test_clk_en;
        int en_edges;
        bit en;
        bit seen;
        out_ready = 1'b1;
        clk_en = 1'b1;
        data_in = P1;
        key128 = K1;
        in_valid128 = 1'b1;
        tick();
        in_valid128 = 1'b0;
        en_edges = 0;
        seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            clk_en = ~clk_en;
            en = clk_en;
            tick();
            if (en) en_edges++;
            if (out_valid128 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen || en_edges != 10) begin
            fails++;
            $display("[TB] FAIL clken_latency: seen=%b enabled_edges=%0d want 1 10", seen, en_edges);
        end
        tests++;
        if (data_out128 !== C1) begin
            fails++;
            $display("[TB] FAIL clken_data: got %h want %h", data_out128, C1);
        end
        clk_en = 1'b0;
        tick();
        tests++;
        if (out_valid128 !== 1'b1 || data_out128 !== C1) begin
            fails++;
            $display("[TB] FAIL clken_hold: out_valid=%b data=%h want 1 %h", out_valid128, data_out128, C1);
        end
        clk_en = 1'b1;
        tick();
        tests++;
        if (out_valid128 !== 1'b0 || in_ready128 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL clken_release: out_valid=%b in_ready=%b want 0 1", out_valid128, in_ready128);
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] ct;
        int lat;
        bit rose;
        data_in = P1;
        key128 = K1;
        in_valid128 = 1'b1;
        tick();
        in_valid128 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        clk_en = 1'b0;
        tick();
        rst = 1'b0;
        clk_en = 1'b1;
        tests++;
        if (busy128 !== 1'b0 || in_ready128 !== 1'b1 || out_valid128 !== 1'b0 || data_out128 !== 128'h0) begin
            fails++;
            $display("[TB] FAIL midreset_state: busy=%b in_ready=%b out_valid=%b data=%h want 0 1 0 0",
                     busy128, in_ready128, out_valid128, data_out128);
        end
        rose = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid128 !== 1'b0) rose = 1'b1;
        end
        tests++;
        if (rose) begin
            fails++;
            $display("[TB] FAIL midreset_no_output: out_valid rose=%b want 0", rose);
        end
        run_job(1'b0, {128'h0, K1}, P1, ct, lat);
        tests++;
        if (ct !== C1 || lat != 10) begin
            fails++;
            $display("[TB] FAIL midreset_rerun: got %h lat %0d want %h lat 10", ct, lat, C1);
        end
    endtask

    task automatic test_back_to_back;
        int acc2, lat1, lat2;
        logic [127:0] c1, c2;
        bit rdy;
        out_ready = 1'b1;
        data_in = P1;
        key128 = K1;
        in_valid128 = 1'b1;
        tick();
        data_in = '0;
        key128 = '0;
        acc2 = -1;
        lat1 = -1;
        lat2 = -1;
        c1 = '0;
        c2 = '0;
        for (int n = 1; n <= 40; n++) begin
            rdy = in_ready128;
            tick();
            if (out_valid128 === 1'b1 && lat1 < 0) begin
                lat1 = n;
                c1 = data_out128;
            end
            if (rdy && acc2 < 0) begin
                acc2 = n;
                in_valid128 = 1'b0;
            end
            if (acc2 > 0 && n > acc2 && out_valid128 === 1'b1) begin
                lat2 = n - acc2;
                c2 = data_out128;
                break;
            end
        end
        in_valid128 = 1'b0;
        tick();
        tests++;
        if (lat1 != 10 || c1 !== C1) begin
            fails++;
            $display("[TB] FAIL b2b_first: lat %0d data %h want 10 %h", lat1, c1, C1);
        end
        tests++;
        if (acc2 != 12) begin
            fails++;
            $display("[TB] FAIL b2b_accept_interval: got %0d want 12", acc2);
        end
        tests++;
        if (lat2 != 10 || c2 !== CZ) begin
            fails++;
            $display("[TB] FAIL b2b_second: lat %0d data %h want 10 %h", lat2, c2, CZ);
        end
    endtask

    // Test sequence
    initial begin
        build_sbox();
        test_reset();
        test_fips128();
        test_fips256();
        test_random();
        test_backpressure();
        test_clk_en();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
